fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port frame-buffer RAM (15-bit address, 4-bit pixel) between two requesters: VGA scanout and the draw engine.
- The scanout side is driven by vga_controller and address_translator. It has hard real-time priority.
- The draw engine gets every remaining memory slot through a req/gnt handshake, and can optionally be restricted to blanking intervals.
- Read data is returned to whichever requester issued the read, after the fixed RAM latency.

Parameters:
- ADDR_W, 15, frame-buffer address width
- DATA_W, 4, pixel width
- MEM_LAT, 1, RAM read latency in Clk cycles (1..3)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous active-low reset (0 = reset)
- blank_only  in  1  1: draw engine granted only while display_en=0
- display_en  in  1  1 during active video, from vga_controller
- vga_req  in  1  single-cycle read request, one per pixel
- vga_addr  in  ADDR_W  scanout read address
- vga_data  out  DATA_W  scanout read data
- vga_valid  out  1  vga_data valid this cycle
- draw_req  in  1  draw request; held until draw_gnt
- draw_we  in  1  1 write, 0 read
- draw_addr  in  ADDR_W  draw address
- draw_wdata  in  DATA_W  draw write data
- draw_gnt  out  1  request issued to RAM this cycle
- draw_rdata  out  DATA_W  draw read data
- draw_rvalid  out  1  draw_rdata valid this cycle
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, MEM_LAT cycles after address
- proto_err  out  1  sticky: vga_req asserted on two consecutive cycles

Behaviour:
- Reset (asynchronous, Reset=0): all outputs 0; tag pipeline cleared; proto_err cleared.
  - Requests in flight at reset never produce vga_valid or draw_rvalid after release.
- Issue stage is combinational from inputs; mem_* outputs are registered, so RAM sees the request one cycle after it is presented.
- Priority each cycle:
  - vga_req=1: issue VGA read (mem_we=0, mem_addr=vga_addr); draw_gnt=0.
  - else draw_req=1 and (blank_only=0 or display_en=0): issue draw op; draw_gnt=1 for exactly that cycle.
    - Write: mem_we=1, mem_wdata=draw_wdata.
    - Read: mem_we=0.
  - else idle: mem_we=0; mem_addr holds its previous value.
- Draw side rules:
  - Requester must hold draw_req, draw_we, draw_addr and draw_wdata stable until draw_gnt.
  - The next request may be presented in the cycle after gnt.
  - Back-to-back grants are allowed when the VGA side is idle.
- Tag pipeline:
  - Every issued op pushes a tag {NONE, VGA, DRAW_RD}; writes push NONE.
  - Depth = 1 (mem_* register) + MEM_LAT.
  - At the pipeline tail:
    - Tag VGA → vga_valid=1, vga_data=mem_rdata.
    - Tag DRAW_RD → draw_rvalid=1, draw_rdata=mem_rdata.
  - Data outputs hold their last value when the corresponding valid is 0.
- Total read latency is MEM_LAT+1 cycles from request to valid: 2 cycles at the default.
- Write followed by read to the same address returns the new data (RAM ordering preserved; no bypass needed).
- vga_req on consecutive cycles: both are serviced, and proto_err is set. It stays set until reset.
- blank_only changes take effect the same cycle; an un-granted draw_req simply waits.
- display_en falling during a held draw_req with blank_only=1: grant in the first cycle where display_en=0 and vga_req=0.

Decomposition:
- Package fb_pkg holds:
  - FB_ADDR_W=15, FB_DATA_W=4
  - typedef enum logic [1:0] fb_tag_t {TAG_NONE, TAG_VGA, TAG_DRAW_RD}
- Sub-module fb_tag_pipe: parameterised-depth shift register of fb_tag_t with asynchronous active-low clear, instantiated once.

Test Plan:
- Reset=0 mid-stream, with a VGA read in flight → all outputs 0 immediately; no vga_valid during the 3 cycles after release.
- vga_req at addr 0x0100 (RAM holds 0xA) → mem_addr=0x0100 next cycle; vga_valid=1 with vga_data=0xA exactly 2 cycles after the request.
- draw_req write 0x7FFF←0x5 in the same cycle as vga_req → draw_gnt=0 that cycle, 1 the next; the following draw read of 0x7FFF returns draw_rvalid with 0x5.
- blank_only=1, display_en=1, draw_req held 20 cycles → draw_gnt=0 throughout; display_en→0 → draw_gnt=1 in that cycle, provided vga_req=0.
- vga_req every other cycle with draw_req held continuously → draw_gnt lands in every gap; vga_valid cadence is unchanged; draw and VGA read data are never swapped.
- vga_req high for 2 consecutive cycles → both reads return in order, and proto_err=1 stays set until Reset=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 4;

  // Identifies who owns the read data emerging from the RAM pipeline.
  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_VGA     = 2'd1,
    TAG_DRAW_RD = 2'd2
  } fb_tag_t;

  // Tag pushed for the op issued this cycle; writes and idle cycles carry no data back.
  function automatic fb_tag_t fb_issue_tag(input logic vga, input logic draw, input logic we);
    fb_tag_t tag;
    if (vga) begin
      tag = TAG_VGA;
    end else if (draw && !we) begin
      tag = TAG_DRAW_RD;
    end else begin
      tag = TAG_NONE;
    end
    return tag;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its two requesters and the RAM.
// slave = arbiter view, master = requesters/RAM view.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = fb_pkg::FB_ADDR_W,
  parameter int DATA_W = fb_pkg::FB_DATA_W
) ();

  logic              blank_only;
  logic              display_en;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              draw_req;
  logic              draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;
  logic [DATA_W-1:0] draw_rdata;
  logic              draw_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              proto_err;

  modport slave (
    input  blank_only, display_en, vga_req, vga_addr,
    input  draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    output vga_data, vga_valid, draw_gnt, draw_rdata, draw_rvalid,
    output mem_addr, mem_we, mem_wdata, proto_err
  );

  modport master (
    output blank_only, display_en, vga_req, vga_addr,
    output draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    input  vga_data, vga_valid, draw_gnt, draw_rdata, draw_rvalid,
    input  mem_addr, mem_we, mem_wdata, proto_err
  );

endinterface

// File: rtl/fb_tag_pipe.sv
// Shift register of ownership tags that tracks reads through the RAM latency.
module fb_tag_pipe
  import fb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  fb_tag_t tag_in,
  output fb_tag_t tag_out
);

  fb_tag_t stage_r [DEPTH];

  // Advance tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= TAG_NONE;
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA scanout has absolute priority, the draw
// engine takes every free slot (optionally only during blanking), and read
// data is steered back to its issuer after the fixed RAM latency.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W,
  parameter int MEM_LAT = 1
) (
  input logic               Clk,
  input logic               Reset,
  fb_port_arbiter_if.slave  bus
);

  // One stage for the mem_* register plus the RAM read latency.
  localparam int PIPE_DEPTH = 1 + MEM_LAT;

  logic              issue_vga_s;
  logic              issue_draw_s;
  logic              draw_window_s;
  fb_tag_t           issue_tag_s;
  fb_tag_t           tail_tag_s;
  logic              vga_valid_s;
  logic              draw_rvalid_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] vga_data_r;
  logic [DATA_W-1:0] draw_rdata_r;
  logic              prev_vga_req_r;
  logic              proto_err_r;

  // Decide this cycle's owner of the RAM slot from the live inputs.
  always_comb begin
    issue_vga_s   = bus.vga_req;
    draw_window_s = !bus.blank_only || !bus.display_en;
    if (bus.vga_req) begin
      issue_draw_s = 1'b0;
    end else begin
      issue_draw_s = bus.draw_req && draw_window_s;
    end
    issue_tag_s = fb_issue_tag(issue_vga_s, issue_draw_s, bus.draw_we);
  end

  // Register the chosen op toward the RAM; idle keeps the address, drops we.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
    end else if (issue_vga_s) begin
      mem_addr_r <= bus.vga_addr;
      mem_we_r   <= 1'b0;
    end else if (issue_draw_s) begin
      mem_addr_r <= bus.draw_addr;
      mem_we_r   <= bus.draw_we;
      if (bus.draw_we) begin
        mem_wdata_r <= bus.draw_wdata;
      end
    end else begin
      mem_we_r <= 1'b0;
    end
  end

  // Flag back-to-back scanout requests; sticky until reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_vga_req_r <= 1'b0;
      proto_err_r    <= 1'b0;
    end else begin
      prev_vga_req_r <= bus.vga_req;
      if (bus.vga_req && prev_vga_req_r) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  fb_tag_pipe #(.DEPTH(PIPE_DEPTH)) u_tag_pipe (
    .clk     (Clk),
    .rst_n   (Reset),
    .tag_in  (issue_tag_s),
    .tag_out (tail_tag_s)
  );

  assign vga_valid_s   = (tail_tag_s == TAG_VGA);
  assign draw_rvalid_s = (tail_tag_s == TAG_DRAW_RD);

  // Remember the last delivered word per requester so data holds between valids.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vga_data_r   <= '0;
      draw_rdata_r <= '0;
    end else begin
      if (vga_valid_s) begin
        vga_data_r <= bus.mem_rdata;
      end
      if (draw_rvalid_s) begin
        draw_rdata_r <= bus.mem_rdata;
      end
    end
  end

  // RAM data arrives in the tail cycle itself, so valid cycles pass it straight through.
  assign bus.vga_valid   = vga_valid_s;
  assign bus.vga_data    = vga_valid_s ? bus.mem_rdata : vga_data_r;
  assign bus.draw_rvalid = draw_rvalid_s;
  assign bus.draw_rdata  = draw_rvalid_s ? bus.mem_rdata : draw_rdata_r;
  // The grant acknowledges the combinational issue decision; forced low in reset.
  assign bus.draw_gnt    = issue_draw_s && Reset;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.proto_err   = proto_err_r;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed testbench for fb_port_arbiter with a 1-cycle-latency RAM model.
module tb_fb_port_arbiter;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;
  logic [3:0]  ram [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [3:0]  pre_data;
  logic [31:0] all_out;

  fb_port_arbiter_if #(.ADDR_W(15), .DATA_W(4)) bus_if ();

  fb_port_arbiter #(.ADDR_W(15), .DATA_W(4), .MEM_LAT(1)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one cycle read latency; preload port used only during reset.
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (bus_if.mem_we) begin
      ram[bus_if.mem_addr] <= bus_if.mem_wdata;
    end
    bus_if.mem_rdata <= ram[bus_if.mem_addr];
  end

  assign all_out = {bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata, bus_if.vga_valid,
                    bus_if.vga_data, bus_if.draw_gnt, bus_if.draw_rvalid, bus_if.draw_rdata,
                    bus_if.proto_err};

  // Each cycle: inputs driven 1 time unit after posedge, outputs checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [3:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1;
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.draw_req = 1'b1;
    bus_if.draw_we  = 1'b0;
    #1;
    checks++;
    if (all_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", all_out, 32'h0);
    end
    bus_if.draw_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_vga_read();
    step();
    bus_if.vga_req  = 1'b1;
    bus_if.vga_addr = 15'h0100;
    step();
    bus_if.vga_req = 1'b0;
    #1;
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_we} !== {15'h0100, 1'b0}) begin
      errors++;
      $display("FAIL vga_issue_addr: got %h/%b expected 0100/0", bus_if.mem_addr, bus_if.mem_we);
    end
    checks++;
    if (bus_if.vga_valid !== 1'b0) begin
      errors++;
      $display("FAIL vga_early_valid: got %b expected 0", bus_if.vga_valid);
    end
    step();
    #1;
    checks++;
    if ({bus_if.vga_valid, bus_if.vga_data} !== 5'h1A) begin
      errors++;
      $display("FAIL vga_read_data: got %h expected %h", {bus_if.vga_valid, bus_if.vga_data}, 5'h1A);
    end
    step();
    #1;
    checks++;
    if ({bus_if.vga_valid, bus_if.vga_data} !== 5'h0A) begin
      errors++;
      $display("FAIL vga_data_hold: got %h expected %h", {bus_if.vga_valid, bus_if.vga_data}, 5'h0A);
    end
  endtask

  task automatic test_priority();
    step();
    bus_if.vga_req    = 1'b1;
    bus_if.vga_addr   = 15'h0200;
    bus_if.draw_req   = 1'b1;
    bus_if.draw_we    = 1'b1;
    bus_if.draw_addr  = 15'h7FFF;
    bus_if.draw_wdata = 4'h5;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b0) begin
      errors++;
      $display("FAIL prio_gnt_blocked: got %b expected 0", bus_if.draw_gnt);
    end
    step();
    bus_if.vga_req = 1'b0;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL prio_gnt_next: got %b expected 1", bus_if.draw_gnt);
    end
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_we} !== {15'h0200, 1'b0}) begin
      errors++;
      $display("FAIL prio_vga_issue: got %h/%b expected 0200/0", bus_if.mem_addr, bus_if.mem_we);
    end
    step();
    bus_if.draw_we = 1'b0;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gnt: got %b expected 1", bus_if.draw_gnt);
    end
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata} !== {15'h7FFF, 1'b1, 4'h5}) begin
      errors++;
      $display("FAIL draw_write_issue: got %h/%b/%h expected 7fff/1/5", bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata);
    end
    checks++;
    if ({bus_if.vga_valid, bus_if.vga_data} !== 5'h13) begin
      errors++;
      $display("FAIL prio_vga_data: got %h expected %h", {bus_if.vga_valid, bus_if.vga_data}, 5'h13);
    end
    step();
    bus_if.draw_req = 1'b0;
    #1;
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_we, bus_if.draw_rvalid} !== {15'h7FFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL draw_read_issue: got %h/%b/%b expected 7fff/0/0", bus_if.mem_addr, bus_if.mem_we, bus_if.draw_rvalid);
    end
    step();
    #1;
    checks++;
    if ({bus_if.draw_rvalid, bus_if.draw_rdata, bus_if.vga_valid} !== 6'b1_0101_0) begin
      errors++;
      $display("FAIL raw_read_data: got %b expected %b", {bus_if.draw_rvalid, bus_if.draw_rdata, bus_if.vga_valid}, 6'b1_0101_0);
    end
    step();
    #1;
    checks++;
    if ({bus_if.draw_rvalid, bus_if.draw_rdata} !== 5'h05) begin
      errors++;
      $display("FAIL draw_data_hold: got %h expected %h", {bus_if.draw_rvalid, bus_if.draw_rdata}, 5'h05);
    end
  endtask

  task automatic test_blank_only();
    step();
    bus_if.blank_only = 1'b1;
    bus_if.display_en = 1'b1;
    bus_if.draw_req   = 1'b1;
    bus_if.draw_we    = 1'b1;
    bus_if.draw_addr  = 15'h0042;
    bus_if.draw_wdata = 4'h9;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      #1;
      checks++;
      if (bus_if.draw_gnt !== 1'b0) begin
        errors++;
        $display("FAIL blank_hold_gnt[%0d]: got %b expected 0", i, bus_if.draw_gnt);
      end
    end
    step();
    bus_if.display_en = 1'b0;
    bus_if.vga_req    = 1'b1;
    bus_if.vga_addr   = 15'h0100;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b0) begin
      errors++;
      $display("FAIL blank_vga_prio: got %b expected 0", bus_if.draw_gnt);
    end
    step();
    bus_if.vga_req = 1'b0;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL blank_release_gnt: got %b expected 1", bus_if.draw_gnt);
    end
    step();
    bus_if.draw_req = 1'b0;
    #1;
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata, bus_if.vga_valid, bus_if.vga_data} !== {15'h0042, 1'b1, 4'h9, 1'b1, 4'hA}) begin
      errors++;
      $display("FAIL blank_write_issue: got %h/%b/%h vga %b/%h expected 0042/1/9 vga 1/a",
               bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata, bus_if.vga_valid, bus_if.vga_data);
    end
    step();
    bus_if.blank_only = 1'b0;
    bus_if.display_en = 1'b1;
    bus_if.draw_req   = 1'b1;
    bus_if.draw_we    = 1'b0;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL blank_off_gnt: got %b expected 1", bus_if.draw_gnt);
    end
    step();
    bus_if.draw_req   = 1'b0;
    bus_if.display_en = 1'b0;
    step();
    #1;
    checks++;
    if ({bus_if.draw_rvalid, bus_if.draw_rdata} !== 5'h19) begin
      errors++;
      $display("FAIL blank_readback: got %h expected %h", {bus_if.draw_rvalid, bus_if.draw_rdata}, 5'h19);
    end
  endtask

  task automatic test_interleave();
    logic       exp_gnt;
    logic       exp_vv;
    logic       exp_dv;
    logic [3:0] exp_d;
    for (int c = 0; c <= 10; c++) begin
      step();
      bus_if.vga_req   = (c < 8) && (c % 2 == 0);
      bus_if.vga_addr  = 15'h0300 + 15'(c / 2);
      bus_if.draw_req  = (c < 8);
      bus_if.draw_we   = 1'b0;
      bus_if.draw_addr = 15'h0400 + 15'(c / 2);
      #1;
      exp_gnt = (c < 8) && (c % 2 == 1);
      exp_vv  = (c >= 2) && (c <= 8) && (c % 2 == 0);
      exp_dv  = (c >= 3) && (c <= 9) && (c % 2 == 1);
      checks++;
      if ({bus_if.draw_gnt, bus_if.vga_valid, bus_if.draw_rvalid} !== {exp_gnt, exp_vv, exp_dv}) begin
        errors++;
        $display("FAIL interleave_ctl[%0d]: got gnt/vv/dv %b expected %b", c,
                 {bus_if.draw_gnt, bus_if.vga_valid, bus_if.draw_rvalid}, {exp_gnt, exp_vv, exp_dv});
      end
      if (exp_vv) begin
        exp_d = 4'((c - 2) / 2 + 1);
        checks++;
        if (bus_if.vga_data !== exp_d) begin
          errors++;
          $display("FAIL interleave_vga_data[%0d]: got %h expected %h", c, bus_if.vga_data, exp_d);
        end
      end
      if (exp_dv) begin
        exp_d = 4'(8 + (c - 3) / 2);
        checks++;
        if (bus_if.draw_rdata !== exp_d) begin
          errors++;
          $display("FAIL interleave_draw_data[%0d]: got %h expected %h", c, bus_if.draw_rdata, exp_d);
        end
      end
    end
    checks++;
    if (bus_if.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL interleave_no_proto_err: got %b expected 0", bus_if.proto_err);
    end
  endtask

  task automatic test_consecutive_vga();
    step();
    bus_if.vga_req  = 1'b1;
    bus_if.vga_addr = 15'h0500;
    step();
    bus_if.vga_addr = 15'h0501;
    #1;
    checks++;
    if (bus_if.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_early: got %b expected 0", bus_if.proto_err);
    end
    step();
    bus_if.vga_req = 1'b0;
    #1;
    checks++;
    if ({bus_if.proto_err, bus_if.vga_valid, bus_if.vga_data} !== 6'b1_1_0110) begin
      errors++;
      $display("FAIL consec_first: got %b expected %b", {bus_if.proto_err, bus_if.vga_valid, bus_if.vga_data}, 6'b1_1_0110);
    end
    step();
    #1;
    checks++;
    if ({bus_if.vga_valid, bus_if.vga_data} !== 5'h17) begin
      errors++;
      $display("FAIL consec_second: got %h expected %h", {bus_if.vga_valid, bus_if.vga_data}, 5'h17);
    end
    repeat (4) step();
    #1;
    checks++;
    if (bus_if.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_sticky: got %b expected 1", bus_if.proto_err);
    end
  endtask

  task automatic test_reset_midstream();
    step();
    bus_if.vga_req   = 1'b1;
    bus_if.vga_addr  = 15'h0100;
    bus_if.draw_req  = 1'b1;
    bus_if.draw_we   = 1'b0;
    bus_if.draw_addr = 15'h0400;
    step();
    bus_if.vga_req = 1'b0;
    #1;
    checks++;
    if (bus_if.draw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre_gnt: got %b expected 1", bus_if.draw_gnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected %h", all_out, 32'h0);
    end
    step();
    step();
    rst_n           = 1'b1;
    bus_if.draw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checks++;
      if ({bus_if.vga_valid, bus_if.draw_rvalid, bus_if.proto_err} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_no_valid[%0d]: got %b expected 000", i,
                 {bus_if.vga_valid, bus_if.draw_rvalid, bus_if.proto_err});
      end
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    pre_we            = 1'b0;
    pre_addr          = 15'h0;
    pre_data          = 4'h0;
    bus_if.blank_only = 1'b0;
    bus_if.display_en = 1'b0;
    bus_if.vga_req    = 1'b0;
    bus_if.vga_addr   = 15'h0;
    bus_if.draw_req   = 1'b0;
    bus_if.draw_we    = 1'b0;
    bus_if.draw_addr  = 15'h0;
    bus_if.draw_wdata = 4'h0;
    step();
    preload(15'h0100, 4'hA);
    preload(15'h0200, 4'h3);
    for (int j = 0; j < 4; j++) begin
      preload(15'h0300 + 15'(j), 4'(j + 1));
      preload(15'h0400 + 15'(j), 4'(8 + j));
    end
    preload(15'h0500, 4'h6);
    preload(15'h0501, 4'h7);
    test_reset();
    test_vga_read();
    test_priority();
    test_blank_only();
    test_interleave();
    test_consecutive_vga();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
